// File: rtl/y86_pkg.sv
// -----------------------------------------------------------------------------
// y86_pkg
// Shared Y86-64 definitions used by the register file and its read ports:
//   - processor status codes (STAT_*)
//   - architectural register indices (REG_*), including REG_RNONE ("no register")
//   - register-file state encoding (rf_state_e)
// -----------------------------------------------------------------------------
package y86_pkg;

  // Processor status codes carried alongside each committing instruction.
  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  // Architectural register indices.
  localparam logic [3:0] REG_RAX   = 4'h0;
  localparam logic [3:0] REG_RCX   = 4'h1;
  localparam logic [3:0] REG_RDX   = 4'h2;
  localparam logic [3:0] REG_RBX   = 4'h3;
  localparam logic [3:0] REG_RSP   = 4'h4;
  localparam logic [3:0] REG_RBP   = 4'h5;
  localparam logic [3:0] REG_RSI   = 4'h6;
  localparam logic [3:0] REG_RDI   = 4'h7;
  localparam logic [3:0] REG_R8    = 4'h8;
  localparam logic [3:0] REG_R9    = 4'h9;
  localparam logic [3:0] REG_R10   = 4'hA;
  localparam logic [3:0] REG_R11   = 4'hB;
  localparam logic [3:0] REG_R12   = 4'hC;
  localparam logic [3:0] REG_R13   = 4'hD;
  localparam logic [3:0] REG_R14   = 4'hE;
  localparam logic [3:0] REG_RNONE = 4'hF;

  // Register-file run state: RUN accepts commits, HALT is sticky until reset.
  typedef enum logic {
    RF_RUN  = 1'b0,
    RF_HALT = 1'b1
  } rf_state_e;

endpackage

// File: rtl/y86_reg_file_if.sv
// -----------------------------------------------------------------------------
// y86_reg_file_if
// Decode/write-back bundle for the Y86-64 register file.
//   master : decode/write-back side (drives indices, write data, status)
//   slave  : register file (returns read data, status, halted, write count)
// Signals: srcA/srcB -> valA/valB (reads), wr_en/dstE/valE/dstM/valM/stat_in
// (commit), stat_out/halted/wr_count (status back to the core).
// -----------------------------------------------------------------------------
interface y86_reg_file_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 32
);

  logic [ADDR_W-1:0] srcA;
  logic [ADDR_W-1:0] srcB;
  logic [DATA_W-1:0] valA;
  logic [DATA_W-1:0] valB;
  logic              wr_en;
  logic [ADDR_W-1:0] dstE;
  logic [DATA_W-1:0] valE;
  logic [ADDR_W-1:0] dstM;
  logic [DATA_W-1:0] valM;
  logic [2:0]        stat_in;
  logic [2:0]        stat_out;
  logic              halted;
  logic [CNT_W-1:0]  wr_count;

  modport master (
    output srcA, srcB, wr_en, dstE, valE, dstM, valM, stat_in,
    input  valA, valB, stat_out, halted, wr_count
  );

  modport slave (
    input  srcA, srcB, wr_en, dstE, valE, dstM, valM, stat_in,
    output valA, valB, stat_out, halted, wr_count
  );

endinterface

// File: rtl/y86_rf_read_port.sv
// -----------------------------------------------------------------------------
// y86_rf_read_port
// One combinational register-file read port.
//   src    : read index
//   stored : array word currently held at src
//   val    : read result; RNONE always reads zero
// With Y86_REG_FILE_BYPASS_EN defined, extra inputs byp_en/dstE/valE/dstM/valM
// forward this cycle's qualified write data (M over E) to the read.
// -----------------------------------------------------------------------------
module y86_rf_read_port #(
  parameter int                DATA_W = 64,
  parameter int                ADDR_W = 4,
  parameter logic [ADDR_W-1:0] RNONE  = '1
) (
  input  logic [ADDR_W-1:0] src,
  input  logic [DATA_W-1:0] stored,
`ifdef Y86_REG_FILE_BYPASS_EN
  input  logic              byp_en,
  input  logic [ADDR_W-1:0] dstE,
  input  logic [DATA_W-1:0] valE,
  input  logic [ADDR_W-1:0] dstM,
  input  logic [DATA_W-1:0] valM,
`endif
  output logic [DATA_W-1:0] val
);

  // NOTE: every path assigns val first, so no latch can be inferred.
  always_comb begin
    val = stored;
`ifdef Y86_REG_FILE_BYPASS_EN
    // Same order as the write priority: M shadows E on a shared index.
    if (byp_en && (src == dstM)) begin
      val = valM;
    end else if (byp_en && (src == dstE)) begin
      val = valE;
    end
`endif
    if (src == RNONE) begin
      val = '0;
    end
  end

endmodule

// File: rtl/y86_reg_file.sv
// -----------------------------------------------------------------------------
// y86_reg_file
// Y86-64 architectural register file with status/halt latch and a saturating
// committed-write counter.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (array to INIT_MODE values, RUN, AOK)
//   bus   : y86_reg_file_if.slave -- two combinational reads (srcA/srcB),
//           two write ports (dstE/valE, dstM/valM) qualified by wr_en and
//           stat_in, plus stat_out/halted/wr_count.
// Optional: define Y86_REG_FILE_BYPASS_EN for write-through read forwarding.
// -----------------------------------------------------------------------------
module y86_reg_file
  import y86_pkg::*;
#(
  parameter int                DATA_W    = 64,
  parameter int                ADDR_W    = 4,
  parameter logic [ADDR_W-1:0] RNONE     = ADDR_W'(REG_RNONE),
  parameter int                INIT_MODE = 1,
  parameter int                CNT_W     = 32
) (
  input logic           clk,
  input logic           rst_n,
  y86_reg_file_if.slave bus
);

  localparam int NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [NREGS];

  rf_state_e         state, state_next;
  logic [2:0]        stat_q, stat_next;
  logic [CNT_W-1:0]  cnt_q, cnt_next;

  // A commit only takes effect in RUN with a good status; any other status
  // suppresses the whole instruction's writes on the edge that halts.
  logic commit_ok;
  logic e_wr, m_wr;

  assign commit_ok = bus.wr_en && (state == RF_RUN) && (bus.stat_in == STAT_AOK);
  assign e_wr      = commit_ok && (bus.dstE != RNONE);
  assign m_wr      = commit_ok && (bus.dstM != RNONE);

  // ---------------------------------------------------------------------------
  // Register array
  // ---------------------------------------------------------------------------
  // NOTE: the array is small and its reset contents are architecturally
  // visible, so it is built from resettable flops rather than a RAM macro.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= (INIT_MODE == 1) ? DATA_W'(i) : '0;
      end
    end else begin
      // NOTE: non-blocking updates resolve in statement order, so the M write
      // placed second wins when dstE == dstM (popq %rsp semantics).
      if (e_wr) regs[bus.dstE] <= bus.valE;
      if (m_wr) regs[bus.dstM] <= bus.valM;
    end
  end

  // ---------------------------------------------------------------------------
  // State machine, status latch and counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= RF_RUN;
      stat_q <= STAT_AOK;
      cnt_q  <= '0;
    end else begin
      state  <= state_next;
      stat_q <= stat_next;
      cnt_q  <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    stat_next  = stat_q;
    cnt_next   = cnt_q;
    case (state)
      RF_RUN: begin
        if (bus.wr_en && (bus.stat_in != STAT_AOK)) begin
          state_next = RF_HALT;
          stat_next  = bus.stat_in;
        end
      end
      RF_HALT: begin
        // Sticky: only reset leaves HALT.
      end
      default: begin
        state_next = RF_HALT;
      end
    endcase
    // Counts cycles that actually wrote something; holds at all-ones.
    if ((e_wr || m_wr) && (cnt_q != '1)) begin
      cnt_next = cnt_q + CNT_W'(1);
    end
  end

  assign bus.stat_out = stat_q;
  assign bus.halted   = (state == RF_HALT);
  assign bus.wr_count = cnt_q;

  // ---------------------------------------------------------------------------
  // Read ports
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] stored_a, stored_b;

  assign stored_a = regs[bus.srcA];
  assign stored_b = regs[bus.srcB];

  y86_rf_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .RNONE  (RNONE)
  ) u_read_a (
    .src    (bus.srcA),
    .stored (stored_a),
`ifdef Y86_REG_FILE_BYPASS_EN
    .byp_en (commit_ok),
    .dstE   (bus.dstE),
    .valE   (bus.valE),
    .dstM   (bus.dstM),
    .valM   (bus.valM),
`endif
    .val    (bus.valA)
  );

  y86_rf_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .RNONE  (RNONE)
  ) u_read_b (
    .src    (bus.srcB),
    .stored (stored_b),
`ifdef Y86_REG_FILE_BYPASS_EN
    .byp_en (commit_ok),
    .dstE   (bus.dstE),
    .valE   (bus.valE),
    .dstM   (bus.dstM),
    .valM   (bus.valM),
`endif
    .val    (bus.valB)
  );

endmodule

// File: tb/tb_y86_reg_file.sv
// -----------------------------------------------------------------------------
// tb_y86_reg_file
// Directed bench for y86_reg_file (INIT_MODE=1, CNT_W=2). Each stimulus step
// drives one cycle of inputs just after a rising edge and queues the outputs
// expected during that cycle; a monitor pops one entry per falling edge and
// compares valA, valB, stat_out, halted and wr_count.
// -----------------------------------------------------------------------------
module tb_y86_reg_file;

`ifdef Y86_REG_FILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  y86_reg_file_if #(.DATA_W(64), .ADDR_W(4), .CNT_W(2)) bus ();

  y86_reg_file #(
    .DATA_W    (64),
    .ADDR_W    (4),
    .RNONE     (4'hF),
    .INIT_MODE (1),
    .CNT_W     (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [63:0] a;
    logic [63:0] b;
    logic [2:0]  st;
    logic        h;
    logic [1:0]  cnt;
  } exp_t;

  exp_t sb_q[$];
  exp_t cur;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: one expectation per cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      cur = sb_q.pop_front();
      check({cur.name, ".valA"},     bus.valA,            cur.a);
      check({cur.name, ".valB"},     bus.valB,            cur.b);
      check({cur.name, ".stat_out"}, 64'(bus.stat_out),   64'(cur.st));
      check({cur.name, ".halted"},   64'(bus.halted),     64'(cur.h));
      check({cur.name, ".wr_count"}, 64'(bus.wr_count),   64'(cur.cnt));
    end
  end

  task automatic step(
    input string       name,
    input logic        we,
    input logic [2:0]  st,
    input logic [3:0]  de,
    input logic [63:0] ve,
    input logic [3:0]  dm,
    input logic [63:0] vm,
    input logic [3:0]  sa,
    input logic [3:0]  sb,
    input logic [63:0] ea,
    input logic [63:0] eb,
    input logic [2:0]  est,
    input logic        eh,
    input logic [1:0]  ec
  );
    exp_t e;
    bus.wr_en   = we;
    bus.stat_in = st;
    bus.dstE    = de;
    bus.valE    = ve;
    bus.dstM    = dm;
    bus.valM    = vm;
    bus.srcA    = sa;
    bus.srcB    = sb;
    e.name = name; e.a = ea; e.b = eb; e.st = est; e.h = eh; e.cnt = ec;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n       = 1'b0;
    bus.wr_en   = 1'b0;
    bus.stat_in = 3'd1;
    bus.dstE    = 4'hF;
    bus.valE    = '0;
    bus.dstM    = 4'hF;
    bus.valM    = '0;
    bus.srcA    = 4'h0;
    bus.srcB    = 4'h0;
    @(posedge clk);
    #1;

    //    name            we st de    valE       dm    valM       sA    sB    expA                   expB       st h cnt
    step("reset_hold",    0, 1, 4'hF, 64'h0,     4'hF, 64'h0,     4'h3, 4'hE, 64'd3,                 64'd14,    1, 0, 0);
    rst_n = 1'b1;
    step("reset_release", 0, 1, 4'hF, 64'h0,     4'hF, 64'h0,     4'h3, 4'hE, 64'd3,                 64'd14,    1, 0, 0);
    step("dual_pre",      1, 1, 4'h2, 64'hAAAA,  4'h5, 64'h5555,  4'h2, 4'h5, BYP ? 64'hAAAA : 64'd2,BYP ? 64'h5555 : 64'd5, 1, 0, 0);
    step("dual_post",     0, 1, 4'hF, 64'h0,     4'hF, 64'h0,     4'h2, 4'h5, 64'hAAAA,              64'h5555,  1, 0, 1);
    step("same_pre",      1, 1, 4'h4, 64'h10,    4'h4, 64'h20,    4'h4, 4'h4, BYP ? 64'h20 : 64'd4,  BYP ? 64'h20 : 64'd4, 1, 0, 1);
    step("same_post",     0, 1, 4'hF, 64'h0,     4'hF, 64'h0,     4'h4, 4'hE, 64'h20,                64'd14,    1, 0, 2);
    step("rnone_pre",     1, 1, 4'hF, 64'hDEAD,  4'hF, 64'hBEEF,  4'hF, 4'h4, 64'h0,                 64'h20,    1, 0, 2);
    step("rnone_post",    0, 1, 4'hF, 64'h0,     4'hF, 64'h0,     4'hF, 4'h4, 64'h0,                 64'h20,    1, 0, 2);
    step("bypass_pre",    1, 1, 4'h6, 64'h77,    4'hF, 64'h0,     4'h6, 4'h6, BYP ? 64'h77 : 64'd6,  BYP ? 64'h77 : 64'd6, 1, 0, 2);
    step("bypass_post",   0, 1, 4'hF, 64'h0,     4'hF, 64'h0,     4'h6, 4'h2, 64'h77,                64'hAAAA,  1, 0, 3);
    step("wren0_pre",     0, 3, 4'h3, 64'h123,   4'hF, 64'h0,     4'h3, 4'h0, 64'd3,                 64'd0,     1, 0, 3);
    step("wren0_post",    0, 1, 4'hF, 64'h0,     4'hF, 64'h0,     4'h3, 4'h0, 64'd3,                 64'd0,     1, 0, 3);
    step("halt_pre",      1, 3, 4'h1, 64'h99,    4'hF, 64'h0,     4'h1, 4'h6, 64'd1,                 64'h77,    1, 0, 3);
    step("halt_post",     0, 1, 4'hF, 64'h0,     4'hF, 64'h0,     4'h1, 4'h6, 64'd1,                 64'h77,    3, 1, 3);
    step("halted_pre",    1, 1, 4'h1, 64'h55,    4'h7, 64'h66,    4'h1, 4'h7, 64'd1,                 64'd7,     3, 1, 3);
    step("halted_post",   1, 4, 4'hF, 64'h0,     4'hF, 64'h0,     4'h1, 4'h7, 64'd1,                 64'd7,     3, 1, 3);
    rst_n = 1'b0;
    step("reset_mid",     0, 1, 4'hF, 64'h0,     4'hF, 64'h0,     4'h2, 4'h4, 64'd2,                 64'd4,     1, 0, 0);
    rst_n = 1'b1;
    step("sat0",          1, 1, 4'h8, 64'h1,     4'hF, 64'h0,     4'h8, 4'hF, BYP ? 64'h1 : 64'd8,   64'h0,     1, 0, 0);
    step("sat1",          1, 1, 4'h9, 64'h2,     4'hF, 64'h0,     4'h9, 4'h8, BYP ? 64'h2 : 64'd9,   64'h1,     1, 0, 1);
    step("sat2",          1, 1, 4'hF, 64'h0,     4'hA, 64'h3,     4'hA, 4'h9, BYP ? 64'h3 : 64'd10,  64'h2,     1, 0, 2);
    step("sat3",          1, 1, 4'hB, 64'h4,     4'hB, 64'h5,     4'hB, 4'hA, BYP ? 64'h5 : 64'd11,  64'h3,     1, 0, 3);
    step("sat4",          1, 1, 4'h0, 64'h6,     4'hF, 64'h0,     4'h0, 4'hB, BYP ? 64'h6 : 64'd0,   64'h5,     1, 0, 3);
    step("sat5",          0, 1, 4'hF, 64'h0,     4'hF, 64'h0,     4'h0, 4'hF, 64'h6,                 64'h0,     1, 0, 3);

    // Let the monitor consume the last expectation, then confirm none remain.
    @(negedge clk);
    #1;
    check("sb_drain", 64'(sb_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
